// File: rtl/matmul_stream_engine.sv
// Streaming N x N matrix multiplier: loads A then B as element streams, runs one MAC per
// cycle and emits each C element as big-endian bytes over a valid/ready byte port.
module matmul_stream_engine #(
    parameter int unsigned N      = 3,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NN = N * N;
    localparam int unsigned AW = $clog2(NN);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned NB = ACC_W / 8;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned PW = 2 * DATA_W;

    typedef enum logic [1:0] {StLoadA, StLoadB, StMac, StSend} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     ld_cnt_q, ld_cnt_d;
    logic [IW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
    logic [BW-1:0]     b_q, b_d;
    logic [ACC_W-1:0]  acc_q, acc_d, res_q, res_d;
    logic              done_q, done_d;
    logic              a_we, b_we;

    logic [DATA_W-1:0] a_mem [NN];
    logic [DATA_W-1:0] b_mem [NN];

    logic [AW-1:0]     a_addr, b_addr;
    logic [DATA_W-1:0] a_op, b_op;
    logic [PW-1:0]     a_x, b_x, prod;
    logic [ACC_W-1:0]  prod_ext, mac_sum, res_shift;
    logic [31:0]       shamt;

    // Operand storage is deliberately left unreset; it is always rewritten before use.
    always_ff @(posedge clk) begin
        if (a_we) a_mem[ld_cnt_q] <= in_data;
        if (b_we) b_mem[ld_cnt_q] <= in_data;
    end

    assign a_addr = AW'(32'(i_q) * N + 32'(k_q));
    assign b_addr = AW'(32'(k_q) * N + 32'(j_q));
    assign a_op   = a_mem[a_addr];
    assign b_op   = b_mem[b_addr];

    // Extending both operands to PW keeps the PW-bit product exact in either mode.
    always_comb begin
        if (SIGNED != 0) begin
            a_x      = PW'($signed(a_op));
            b_x      = PW'($signed(b_op));
        end else begin
            a_x      = PW'(a_op);
            b_x      = PW'(b_op);
        end
        prod = a_x * b_x;
        if (SIGNED != 0) prod_ext = ACC_W'($signed(prod));
        else             prod_ext = ACC_W'(prod);
        mac_sum = acc_q + prod_ext;
    end

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        b_d      = b_q;
        acc_d    = acc_q;
        res_d    = res_q;
        done_d   = 1'b0;
        a_we     = 1'b0;
        b_we     = 1'b0;
        unique case (state_q)
            StLoadA: begin
                if (in_valid) begin
                    a_we = 1'b1;
                    if (ld_cnt_q == AW'(NN - 1)) begin
                        ld_cnt_d = '0;
                        state_d  = StLoadB;
                    end else begin
                        ld_cnt_d = ld_cnt_q + AW'(1);
                    end
                end
            end
            StLoadB: begin
                if (in_valid) begin
                    b_we = 1'b1;
                    if (ld_cnt_q == AW'(NN - 1)) begin
                        ld_cnt_d = '0;
                        i_d      = '0;
                        j_d      = '0;
                        k_d      = '0;
                        acc_d    = '0;
                        state_d  = StMac;
                    end else begin
                        ld_cnt_d = ld_cnt_q + AW'(1);
                    end
                end
            end
            StMac: begin
                if (k_q == IW'(N - 1)) begin
                    res_d   = mac_sum;
                    b_d     = '0;
                    state_d = StSend;
                end else begin
                    acc_d = mac_sum;
                    k_d   = k_q + IW'(1);
                end
            end
            StSend: begin
                if (out_ready) begin
                    if (b_q == BW'(NB - 1)) begin
                        b_d   = '0;
                        k_d   = '0;
                        acc_d = '0;
                        if (i_q == IW'(N - 1) && j_q == IW'(N - 1)) begin
                            i_d     = '0;
                            j_d     = '0;
                            done_d  = 1'b1;
                            state_d = StLoadA;
                        end else begin
                            if (j_q != IW'(N - 1)) begin
                                j_d = j_q + IW'(1);
                            end else begin
                                j_d = '0;
                                i_d = i_q + IW'(1);
                            end
                            state_d = StMac;
                        end
                    end else begin
                        b_d = b_q + BW'(1);
                    end
                end
            end
            default: state_d = StLoadA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StLoadA;
            ld_cnt_q <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            done_q   <= done_d;
        end
    end

    // Most significant byte goes out first.
    assign shamt     = (NB - 1 - 32'(b_q)) * 8;
    assign res_shift = res_q >> shamt;

    assign in_ready  = (state_q == StLoadA) || (state_q == StLoadB);
    assign out_valid = (state_q == StSend);
    assign out_data  = (state_q == StSend) ? res_shift[7:0] : 8'h00;
    assign busy      = !((state_q == StLoadA) && (ld_cnt_q == '0));
    assign done      = done_q;

endmodule

// File: doc/matmul_stream_engine.md
Name: matmul_stream_engine

Overview:
- Parametrised N×N matrix-multiply engine. It sits between the UART receive path and the UART transmit path.
- Accepts matrix A, then matrix B, as a row-major element stream with a valid/ready handshake.
- Computes C = A×B with one multiply-accumulate (MAC) per cycle.
- Streams each C element out as big-endian bytes on a valid/ready byte interface that feeds the UART TX.
- Successor to the fixed-size multiplier: adds generic dimension, width, signed mode and backpressure on both sides.

Parameters:
- N, 3: matrix dimension, 2..16.
- DATA_W, 8: width of each A/B element.
- ACC_W, 24: accumulator and result width. Must be a multiple of 8 and at least 2*DATA_W.
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands and products.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- in_data  in  DATA_W  A/B element
- in_valid  in  1  in_data valid
- in_ready  out  1  engine accepts element
- out_data  out  8  result byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream (UART TX) accepts byte
- busy  out  1  high in any state other than LOAD_A with a zero element count
- done  out  1  one-cycle pulse after last byte of C is accepted

Behaviour:
- Reset, asynchronous:
  - State → LOAD_A; all counters = 0.
  - in_ready=1 (combinational from state), out_valid=0, out_data=0, done=0, busy=0, accumulator=0.
  - A/B storage is not reset.
  - Reset mid-operation abandons the current job; no partial output follows release.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - Gaps on in_valid and stalls on out_ready are legal and lossless.
  - out_data must stay stable while out_valid && !out_ready.
- State machine:
  - LOAD_A: in_ready=1. Each transfer writes A[r][c]; c increments, and wraps to 0 with r++. The N*N-th transfer → LOAD_B with r=c=0.
  - LOAD_B: same as LOAD_A, writing B. The N*N-th transfer → MAC with i=j=k=0 and acc=0. in_ready=0 from the next cycle.
  - MAC: each cycle acc <= acc + A[i][k]*B[k][j], then k++.
    - The product is DATA_W×DATA_W → 2*DATA_W, sign- or zero-extended to ACC_W according to SIGNED.
    - The sum wraps modulo 2^ACC_W.
    - On the cycle that adds k=N-1: latch the final sum into res, set byte index b=0 → SEND.
    - MAC takes exactly N cycles per element.
  - SEND: out_valid=1, out_data = res[ACC_W-1-8b -: 8] (most significant byte first).
    - On transfer: b++.
    - On transfer of byte ACC_W/8-1: if j<N-1 then j++; else j=0, i++.
    - If (i,j) was (N-1,N-1): done=1 for one cycle → LOAD_A.
    - Otherwise → MAC with k=0 and acc=0.
- Latency:
  - The first out_valid rises N+1 cycles after the cycle of the last B transfer: 1 state-transition cycle, then N MAC cycles.
  - Each later element adds N cycles of MAC after its predecessor's last byte is accepted.
  - Total output is N*N*ACC_W/8 bytes.
- Back-to-back jobs:
  - in_ready=1 on the cycle after done.
  - A new A element may be accepted that cycle.
  - Stored A/B values are overwritten only as new elements arrive.
- in_valid asserted outside LOAD_A/LOAD_B is ignored (in_ready=0). out_ready outside SEND is ignored.

Test Plan:
- N=3, DATA_W=8, ACC_W=24, unsigned; A=identity, B=1..9 → 27 bytes: 00 00 01, 00 00 02, …, 00 00 09. done pulses once after the 27th byte.
- Unsigned; A=B all 0xFF → every element is 3*65025=195075 → bytes 02 FA 03 repeated 9 times. Verify no truncation.
- SIGNED=1; A all 0xFF (−1), B all 0x02 → every element −6 → bytes FF FF FA ×9.
- Backpressure: in_valid random 50% and out_ready toggling 1/0 per cycle → byte sequence identical to the identity test; out_data held stable during stalls; no drops or duplicates.
- Reset asserted for 2 cycles during MAC of element (1,1) → out_valid=0 and in_ready=1 after release. A fresh load of the identity test yields exactly the 27 correct bytes with no stale output.
- Two jobs back-to-back: second A begins the cycle after done, with B = 2×identity and A=1..9 → second output is 2,4,…,18. Timing: first out_valid exactly N+1=4 cycles after the last B transfer.
